// File: rtl/seg_scan_driver_if.sv
// Write port from the upstream segment peripheral: one-cycle strobe carrying
// the target digit index and its segment pattern.
interface seg_scan_driver_if;
  logic       seg_we;
  logic [2:0] choose;
  logic [7:0] bin;

  modport master (output seg_we, choose, bin);
  modport slave  (input  seg_we, choose, bin);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-digit pattern store plus a
// BLANK/ON scan FSM driving registered segment lines and one-hot digit enables.
//
//   state    | meaning
//   ST_BLANK | all digits and segments off, counting BLANK_CYCLES
//   ST_ON    | digit scan_idx lit with pat[scan_idx], counting ON_CYCLES
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int ON_CYCLES      = 50000,
  parameter int BLANK_CYCLES   = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  seg_scan_driver_if.slave      wr,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [2:0]            scan_idx
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0]         ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [7:0]            SEG_OFF    = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [2:0]            IDX_LAST   = 3'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [7:0]              pat [NUM_DIGITS];
  logic [7:0]              lit_pat;
  logic [NUM_DIGITS-1:0]   lit_onehot;
  logic [2:0]              idx_next;

  // Out-of-range digit indices match no entry, so such writes fall away.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) pat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr.seg_we && (wr.choose == 3'(i))) pat[i] <= wr.bin;
      end
    end
  end

  always_comb begin
    lit_pat    = '0;
    lit_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == 3'(i)) begin
        lit_pat       = pat[i];
        lit_onehot[i] = 1'b1;
      end
    end
  end

  assign idx_next = (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;

  // Outputs are loaded from the pattern store as it stood before this edge,
  // which gives a live write its one-cycle path to seg_out.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      scan_idx <= '0;
      seg_out  <= SEG_OFF;
      dig_sel  <= DIG_OFF;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state   <= ST_ON;
            cnt     <= '0;
            seg_out <= lit_pat ^ SEG_OFF;
            dig_sel <= lit_onehot ^ DIG_OFF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ON: begin
          if (cnt == ON_LAST) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            scan_idx <= idx_next;
            seg_out  <= SEG_OFF;
            dig_sel  <= DIG_OFF;
          end else begin
            cnt     <= cnt + CW'(1);
            seg_out <= lit_pat ^ SEG_OFF;
          end
        end
        default: begin
          state   <= ST_BLANK;
          cnt     <= '0;
          seg_out <= SEG_OFF;
          dig_sel <= DIG_OFF;
        end
      endcase
    end
  end

endmodule
